// File: rtl/ascon_round_scheduler_if.sv
// Handshake bundle between the Ascon mode FSM (master) and the round scheduler (slave).
// Abort signals exist only when ASCON_SCHED_ABORT_EN is defined.
interface ascon_round_scheduler_if;
   logic       i_start;
   logic [3:0] i_num_rounds;
   logic       o_ready;
   logic       o_load;
   logic       o_round_en;
   logic [3:0] o_round;
   logic       o_done;
   logic       o_err;
`ifdef ASCON_SCHED_ABORT_EN
   logic       i_abort;
   logic       o_aborted;

   modport master (output i_start, i_num_rounds, i_abort,
                   input  o_ready, o_load, o_round_en, o_round, o_done, o_err, o_aborted);
   modport slave  (input  i_start, i_num_rounds, i_abort,
                   output o_ready, o_load, o_round_en, o_round, o_done, o_err, o_aborted);
`else
   modport master (output i_start, i_num_rounds,
                   input  o_ready, o_load, o_round_en, o_round, o_done, o_err);
   modport slave  (input  i_start, i_num_rounds,
                   output o_ready, o_load, o_round_en, o_round, o_done, o_err);
`endif
endinterface

// File: rtl/ascon_round_scheduler.sv
// Ascon permutation round scheduler: load/round-enable strobes and round-constant index.
// Optional abort path enabled by defining ASCON_SCHED_ABORT_EN.
//
// state | meaning
// IDLE  | waiting for a permutation request
// LOAD  | state register captures the external input state
// RUN   | one (or two) rounds applied per cycle, o_round = base constant index
// DONE  | final permuted state held; a new request may be accepted here
module ascon_round_scheduler #(
   parameter int ROUNDS_PER_CYCLE = 1,
   parameter int MAX_ROUNDS       = 12
) (
   input logic                     i_clk,
   input logic                     i_rst,
   ascon_round_scheduler_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   localparam logic [4:0] RPC = 5'(ROUNDS_PER_CYCLE);
   localparam logic [4:0] MAXR = 5'(MAX_ROUNDS);

   state_t     state_q, state_d;
   logic [3:0] rnd_q, rnd_d;
   logic       err_q, err_d;
   logic       aborted_q, aborted_d;
   logic       nr_legal;
   logic [4:0] rnd_next;

   // Two-rounds-per-cycle chaining can only finish exactly on MAX_ROUNDS with an even count.
   assign nr_legal = (bus.i_num_rounds != 4'd0) &&
                     ({1'b0, bus.i_num_rounds} <= MAXR) &&
                     ((ROUNDS_PER_CYCLE == 1) || !bus.i_num_rounds[0]);
   assign rnd_next = {1'b0, rnd_q} + RPC;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= IDLE;
         rnd_q     <= '0;
         err_q     <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rnd_q     <= rnd_d;
         err_q     <= err_d;
         aborted_q <= aborted_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      rnd_d     = rnd_q;
      err_d     = 1'b0;
      aborted_d = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (bus.i_start) begin
               if (nr_legal) begin
                  state_d = LOAD;
                  rnd_d   = 4'(MAXR - {1'b0, bus.i_num_rounds});
               end else begin
                  state_d = IDLE;
                  rnd_d   = '0;
                  err_d   = 1'b1;
               end
            end else begin
               state_d = IDLE;
            end
         end
         LOAD: state_d = RUN;
         RUN: begin
            rnd_d = rnd_next[3:0];
            if (rnd_next == MAXR) state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
`ifdef ASCON_SCHED_ABORT_EN
      if (bus.i_abort && (state_q == LOAD || state_q == RUN)) begin
         state_d   = IDLE;
         rnd_d     = '0;
         aborted_d = 1'b1;
      end
`endif
   end

   assign bus.o_ready    = (state_q == IDLE) || (state_q == DONE);
   assign bus.o_load     = (state_q == LOAD);
   assign bus.o_round_en = (state_q == RUN);
   assign bus.o_round    = (state_q == RUN) ? rnd_q : 4'd0;
   assign bus.o_done     = (state_q == DONE);
   assign bus.o_err      = err_q;
`ifdef ASCON_SCHED_ABORT_EN
   assign bus.o_aborted  = aborted_q;
`endif

endmodule

// File: tb/tb_ascon_round_scheduler.sv
// Self-checking bench: one scheduler per ROUNDS_PER_CYCLE value against a per-operation timeline model.
module tb_ascon_round_scheduler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ascon_round_scheduler_if bus1();
   ascon_round_scheduler_if bus2();

   ascon_round_scheduler #(.ROUNDS_PER_CYCLE(1), .MAX_ROUNDS(12)) dut1 (
      .i_clk(clk), .i_rst(rst), .bus(bus1.slave));
   ascon_round_scheduler #(.ROUNDS_PER_CYCLE(2), .MAX_ROUNDS(12)) dut2 (
      .i_clk(clk), .i_rst(rst), .bus(bus2.slave));

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   // Model: an accepted operation is tracked by its age in cycles since the start was sampled.
   bit m_active[2];
   int m_off[2];
   int m_nr[2];
   bit m_err[2];
   bit m_abt[2];

   task automatic chk(string name, logic [9:0] act, logic [9:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   function automatic int rpc(int d);
      return (d == 0) ? 1 : 2;
   endfunction

   function automatic bit legal(int d, int nr);
      return (nr >= 1) && (nr <= 12) && ((nr % rpc(d)) == 0);
   endfunction

   function automatic bit in_start(int d);
      return (d == 0) ? bus1.i_start : bus2.i_start;
   endfunction

   function automatic int in_nr(int d);
      return (d == 0) ? int'(bus1.i_num_rounds) : int'(bus2.i_num_rounds);
   endfunction

   function automatic bit in_abort(int d);
`ifdef ASCON_SCHED_ABORT_EN
      return (d == 0) ? bus1.i_abort : bus2.i_abort;
`else
      return 1'b0;
`endif
   endfunction

   // {ready, load, round_en, round[3:0], done, err, aborted}
   function automatic logic [9:0] dut_out(int d);
      logic ab1, ab2;
`ifdef ASCON_SCHED_ABORT_EN
      ab1 = bus1.o_aborted;
      ab2 = bus2.o_aborted;
`else
      ab1 = 1'b0;
      ab2 = 1'b0;
`endif
      if (d == 0)
         return {bus1.o_ready, bus1.o_load, bus1.o_round_en, bus1.o_round, bus1.o_done, bus1.o_err, ab1};
      return {bus2.o_ready, bus2.o_load, bus2.o_round_en, bus2.o_round, bus2.o_done, bus2.o_err, ab2};
   endfunction

   function automatic logic [9:0] exp_out(int d);
      int n;
      bit ld, re, dn, rdy;
      logic [3:0] rd;
      n   = m_nr[d] / rpc(d);
      ld  = m_active[d] && (m_off[d] == 1);
      re  = m_active[d] && (m_off[d] >= 2) && (m_off[d] <= 1 + n);
      dn  = m_active[d] && (m_off[d] == 2 + n);
      rdy = !m_active[d] || dn;
      rd  = re ? 4'(12 - m_nr[d] + (m_off[d] - 2) * rpc(d)) : 4'd0;
      return {rdy, ld, re, rd, dn, m_err[d], m_abt[d]};
   endfunction

   task automatic model_step(int d);
      int n;
      bit dn, rdy, busy;
      n    = m_nr[d] / rpc(d);
      dn   = m_active[d] && (m_off[d] == 2 + n);
      rdy  = !m_active[d] || dn;
      busy = m_active[d] && (m_off[d] >= 1) && (m_off[d] <= 1 + n);
      m_err[d] = 1'b0;
      m_abt[d] = 1'b0;
      if (rst) begin
         m_active[d] = 1'b0;
      end else if (in_abort(d) && busy) begin
         m_active[d] = 1'b0;
         m_abt[d]    = 1'b1;
      end else if (rdy && in_start(d)) begin
         if (legal(d, in_nr(d))) begin
            m_active[d] = 1'b1;
            m_off[d]    = 1;
            m_nr[d]     = in_nr(d);
         end else begin
            m_active[d] = 1'b0;
            m_err[d]    = 1'b1;
         end
      end else if (m_active[d]) begin
         if (dn) m_active[d] = 1'b0;
         else    m_off[d]++;
      end
   endtask

   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (chk_en) chk((d == 0) ? "outs_rpc1" : "outs_rpc2", dut_out(d), exp_out(d));
         model_step(d);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic sample_point();
      @(negedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus1.i_start = 1'b0;
      bus2.i_start = 1'b0;
`ifdef ASCON_SCHED_ABORT_EN
      bus1.i_abort = 1'b0;
      bus2.i_abort = 1'b0;
`endif
   endtask

   initial begin
      bus1.i_num_rounds = 4'd0;
      bus2.i_num_rounds = 4'd0;
      clear_inputs();
      repeat (3) @(posedge clk);
      #2;
      rst    = 1'b0;
      chk_en = 1'b1;
      sample_point();
      chk("reset_outs", dut_out(0), 10'b1_0_0_0000_0_0_0);

      // p^a on RPC=1 and nr=8 on RPC=2 together, then nr=7 (odd) on RPC=2, then nr=6 back-to-back.
      next_cycle();
      bus1.i_start = 1'b1; bus1.i_num_rounds = 4'd12;
      bus2.i_start = 1'b1; bus2.i_num_rounds = 4'd8;
      for (int c = 1; c <= 23; c++) begin
         next_cycle();
         clear_inputs();
         if (c == 7)  begin bus2.i_start = 1'b1; bus2.i_num_rounds = 4'd7; end
         if (c == 14) begin bus1.i_start = 1'b1; bus1.i_num_rounds = 4'd6; end
         sample_point();
         case (c)
            1:  chk("pa_load_c1", {bus1.o_load, bus1.o_ready}, 10'd2);
            2:  chk("pa_round_c2", {bus1.o_round_en, bus1.o_round, bus2.o_round}, {1'b1, 4'd0, 4'd4});
            5:  chk("rpc2_round_c5", bus2.o_round, 10'd10);
            6:  chk("rpc2_done_c6", bus2.o_done, 10'd1);
            8:  chk("rpc2_odd_err", {bus2.o_err, bus2.o_load, bus2.o_ready}, 10'b101);
            13: chk("pa_round_c13", bus1.o_round, 10'd11);
            14: chk("pa_done_c14", {bus1.o_done, bus1.o_ready}, 10'b11);
            15: chk("b2b_load_c15", bus1.o_load, 10'd1);
            16: chk("b2b_round_c16", bus1.o_round, 10'd6);
            22: chk("b2b_done_c22", bus1.o_done, 10'd1);
            default: ;
         endcase
      end

      // Illegal round counts
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         bus1.i_start = 1'b1;
         bus1.i_num_rounds = (k == 0) ? 4'd0 : (k == 1) ? 4'd13 : 4'd15;
         next_cycle();
         clear_inputs();
         sample_point();
         chk("illegal_err", {bus1.o_err, bus1.o_ready, bus1.o_load, bus1.o_round_en}, 10'b1100);
      end

      // Reset in cycle 5 of p^a, then nr=6 runs to completion.
      next_cycle();
      bus1.i_start = 1'b1; bus1.i_num_rounds = 4'd12;
      for (int c = 1; c <= 5; c++) begin
         next_cycle();
         clear_inputs();
         if (c == 5) rst = 1'b1;
      end
      next_cycle();
      rst = 1'b0;
      bus1.i_start = 1'b1; bus1.i_num_rounds = 4'd6;
      sample_point();
      chk("rst_midrun", dut_out(0), 10'b1_0_0_0000_0_0_0);
      for (int c = 1; c <= 8; c++) begin
         next_cycle();
         clear_inputs();
      end
      sample_point();
      chk("after_rst_done", bus1.o_done, 10'd1);

`ifdef ASCON_SCHED_ABORT_EN
      next_cycle();
      bus1.i_start = 1'b1; bus1.i_num_rounds = 4'd12;
      for (int c = 1; c <= 6; c++) begin
         next_cycle();
         clear_inputs();
         if (c == 4) begin
            bus1.i_abort = 1'b1; bus1.i_start = 1'b1; bus1.i_num_rounds = 4'd12;
         end
         sample_point();
         if (c == 5) chk("abort_c5", {bus1.o_aborted, bus1.o_ready, bus1.o_done}, 10'b110);
         if (c == 6) chk("abort_start_ignored", bus1.o_load, 10'd0);
      end
`endif

      // Randomized traffic, checked every cycle by the compare process.
      for (int i = 0; i < 4000; i++) begin
         next_cycle();
         rst = ($urandom_range(0, 299) == 0);
         bus1.i_start = ($urandom_range(0, 3) == 0);
         bus2.i_start = ($urandom_range(0, 3) == 0);
         bus1.i_num_rounds = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) :
                             4'($urandom_range(1, 12));
         bus2.i_num_rounds = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) :
                             4'(2 * $urandom_range(1, 6));
`ifdef ASCON_SCHED_ABORT_EN
         bus1.i_abort = ($urandom_range(0, 39) == 0);
         bus2.i_abort = ($urandom_range(0, 39) == 0);
`endif
      end
      next_cycle();
      rst = 1'b0;
      clear_inputs();
      repeat (20) next_cycle();
      sample_point();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
